// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multi-cycle RV64I control path (package ctrl_pkg):
// FSM states, opcode classes, major opcodes and ALU operation codes.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_ERROR,
    ST_TRAP
  } state_e;

  typedef enum logic [2:0] {
    CL_R,
    CL_IALU,
    CL_LD,
    CL_SD,
    CL_BEQ,
    CL_ILLEGAL
  } op_class_e;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  function automatic op_class_e classify(input logic [6:0] op);
    op_class_e cls;
    case (op)
      OP_R:    cls = CL_R;
      OP_IALU: cls = CL_IALU;
      OP_LD:   cls = CL_LD;
      OP_SD:   cls = CL_SD;
      OP_BEQ:  cls = CL_BEQ;
      default: cls = CL_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_control.sv
// ALU operation decode: opcode class plus funct3/funct7[5] to alu_ctrl.
// Purely combinational; only meaningful while the controller is in EXEC.
module alu_control
  import ctrl_pkg::*;
(
  input  op_class_e  cls_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  output logic [3:0] alu_ctrl_o
);

  always_comb begin
    alu_ctrl_o = ALU_ADD;
    case (cls_i)
      CL_R, CL_IALU: begin
        case (funct3_i)
          F3_OR:   alu_ctrl_o = ALU_OR;
          F3_AND:  alu_ctrl_o = ALU_AND;
          // Immediate forms have no SUB, so funct7[5] only matters for R-type.
          F3_ADD:  alu_ctrl_o = (cls_i == CL_R && funct7_5_i) ? ALU_SUB : ALU_ADD;
          default: alu_ctrl_o = ALU_ADD;
        endcase
      end
      CL_BEQ:  alu_ctrl_o = ALU_SUB;
      default: alu_ctrl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle RV64I core (R, I-ALU, LD, SD, BEQ).
// Optional: define ILLEGAL_OP_TRAP_EN to add the trap output and TRAP state.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  output logic             imem_req,
  input  logic             imem_ready,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ready,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             reg_write,
  output logic             alu_src_b,
  output logic             mem_to_reg,
  output logic [3:0]       alu_ctrl,
  output logic             busy,
  output logic             error,
  output logic [CNT_W-1:0] instr_count
`ifdef ILLEGAL_OP_TRAP_EN
  ,
  output logic             trap
`endif
);

  localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  op_class_e        cls_q, cls_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;
  logic [3:0]       alu_ctrl_w;

  alu_control u_alu_control (
    .cls_i      (cls_q),
    .funct3_i   (funct3),
    .funct7_5_i (funct7_5),
    .alu_ctrl_o (alu_ctrl_w)
  );

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    tmo_d   = tmo_q;
    retire  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d = ST_FETCH;
          tmo_d   = '0;
        end
      end
      ST_FETCH: begin
        if (imem_ready)            state_d = ST_DECODE;
        else if (tmo_q == TMO_LAST) state_d = ST_ERROR;
        else                        tmo_d   = tmo_q + TMO_W'(1);
      end
      ST_DECODE: begin
        cls_d = classify(opcode);
        if (cls_d == CL_ILLEGAL) begin
`ifdef ILLEGAL_OP_TRAP_EN
          state_d = ST_TRAP;
`else
          retire  = 1'b1;
`endif
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (cls_q)
          CL_BEQ: retire = 1'b1;
          CL_LD, CL_SD: begin
            state_d = ST_MEM;
            tmo_d   = '0;
          end
          default: state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (dmem_ready) begin
          if (cls_q == CL_SD) retire  = 1'b1;
          else                state_d = ST_WB;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_ERROR;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_WB:    retire = 1'b1;
      ST_ERROR: state_d = ST_ERROR;
      ST_TRAP:  state_d = ST_TRAP;
      default:  state_d = ST_IDLE;
    endcase
    // run is only honoured at an instruction boundary.
    if (retire) begin
      state_d = run ? ST_FETCH : ST_IDLE;
      tmo_d   = '0;
    end
    cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cls_q   <= CL_R;
      tmo_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode the asynchronously reset state, so reset drops them at once.
  always_comb begin
    imem_req      = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    reg_write     = 1'b0;
    alu_src_b     = 1'b0;
    mem_to_reg    = 1'b0;
    alu_ctrl      = ALU_AND;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    error         = 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
    trap          = 1'b0;
`endif
    case (state_q)
      ST_FETCH: begin
        imem_req = 1'b1;
        ir_write = imem_ready;
        pc_write = imem_ready;
      end
      ST_EXEC: begin
        alu_ctrl      = alu_ctrl_w;
        alu_src_b     = (cls_q == CL_IALU) || (cls_q == CL_LD) || (cls_q == CL_SD);
        pc_write_cond = (cls_q == CL_BEQ);
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == CL_SD);
      end
      ST_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (cls_q == CL_LD);
      end
      ST_ERROR: error = 1'b1;
`ifdef ILLEGAL_OP_TRAP_EN
      ST_TRAP:  trap  = 1'b1;
`endif
      default: ;
    endcase
  end

  assign busy        = (state_q != ST_IDLE);
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: a per-instruction timing model
// predicts every busy cycle; a monitor pops and compares each one.
module tb_multicycle_controller;

  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned NSTUCK  = 4;
`ifdef ILLEGAL_OP_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, run = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic funct7_5 = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
  logic imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_write_cond;
  logic reg_write, alu_src_b, mem_to_reg, busy, error, trap;
  logic [3:0] alu_ctrl;
  logic [CNT_W-1:0] instr_count;
`ifndef ILLEGAL_OP_TRAP_EN
  assign trap = 1'b0;
`endif

  multicycle_controller #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .funct3(funct3),
    .funct7_5(funct7_5), .imem_req(imem_req), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .reg_write(reg_write), .alu_src_b(alu_src_b), .mem_to_reg(mem_to_reg),
    .alu_ctrl(alu_ctrl), .busy(busy), .error(error), .instr_count(instr_count)
`ifdef ILLEGAL_OP_TRAP_EN
    , .trap(trap)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum {K_ADD, K_SUB, K_OR, K_AND, K_ADDI, K_ORI, K_ANDI, K_LD, K_SD, K_BEQ, K_ILL} mnem_e;

  typedef struct {
    mnem_e       m;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f75;
    int unsigned wf;   // fetch wait cycles before imem_ready
    int unsigned wm;   // data wait cycles before dmem_ready
    bit          last;
  } instr_t;

  typedef struct packed {
    logic       imem_req, ir_write, pc_write, pc_write_cond, reg_write, alu_src_b, mem_to_reg;
    logic [3:0] alu_ctrl;
    logic       dmem_req, dmem_we, error, trap;
  } sig_t;

  typedef struct {
    int unsigned      cyc;
    sig_t             sig;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t   sbq[$];
  instr_t rq[$];
  int unsigned errors = 0, checks = 0;
  logic [CNT_W-1:0] model_cnt = '0;
  int unsigned mt;

  // Instruction semantics by mnemonic.
  function automatic logic [6:0] op_of(mnem_e m);
    case (m)
      K_ADD, K_SUB, K_OR, K_AND: return 7'b0110011;
      K_ADDI, K_ORI, K_ANDI:     return 7'b0010011;
      K_LD:                      return 7'b0000011;
      K_SD:                      return 7'b0100011;
      K_BEQ:                     return 7'b1100011;
      default:                   return 7'h7F;
    endcase
  endfunction

  function automatic logic [3:0] alu_of(mnem_e m);
    case (m)
      K_SUB, K_BEQ:  return 4'b0110;
      K_OR, K_ORI:   return 4'b0001;
      K_AND, K_ANDI: return 4'b0000;
      default:       return 4'b0010;
    endcase
  endfunction

  function automatic instr_t mk(mnem_e m, int unsigned wf, int unsigned wm, bit last);
    instr_t x;
    x.m = m; x.op = op_of(m); x.wf = wf; x.wm = wm; x.last = last;
    x.f3  = 3'($urandom_range(0, 7));
    x.f75 = 1'($urandom_range(0, 1));
    case (m)
      K_ADD:  begin x.f3 = 3'b000; x.f75 = 1'b0; end
      K_SUB:  begin x.f3 = 3'b000; x.f75 = 1'b1; end
      K_OR:   begin x.f3 = 3'b110; x.f75 = 1'b0; end
      K_AND:  begin x.f3 = 3'b111; x.f75 = 1'b0; end
      K_ADDI: x.f3 = 3'b000;
      K_ORI:  x.f3 = 3'b110;
      K_ANDI: x.f3 = 3'b111;
      default: ;
    endcase
    return x;
  endfunction

  function automatic void push(sig_t s);
    exp_t e;
    e.cyc = mt; e.sig = s; e.cnt = model_cnt;
    sbq.push_back(e);
    mt++;
  endfunction

  function automatic void stuck(bit is_trap);
    sig_t s;
    s = '0; s.error = !is_trap; s.trap = is_trap;
    repeat (NSTUCK) push(s);
  endfunction

  // Reference: every busy cycle of a program, from the instruction latency rules.
  task automatic model(input instr_t p[$]);
    sig_t s;
    foreach (p[i]) begin
      s = '0; s.imem_req = 1'b1;
      if (p[i].wf >= TIMEOUT) begin
        repeat (TIMEOUT) push(s);
        stuck(1'b0);
        return;
      end
      repeat (p[i].wf) push(s);
      s.ir_write = 1'b1; s.pc_write = 1'b1;
      push(s);
      push('0);
      if (p[i].m == K_ILL) begin
        if (TRAP_EN) begin
          stuck(1'b1);
          return;
        end
        model_cnt = model_cnt + 1'b1;
        continue;
      end
      s = '0;
      s.alu_src_b     = !(p[i].m inside {K_ADD, K_SUB, K_OR, K_AND, K_BEQ});
      s.alu_ctrl      = alu_of(p[i].m);
      s.pc_write_cond = (p[i].m == K_BEQ);
      push(s);
      if (p[i].m == K_BEQ) begin
        model_cnt = model_cnt + 1'b1;
        continue;
      end
      if (p[i].m inside {K_LD, K_SD}) begin
        s = '0; s.dmem_req = 1'b1; s.dmem_we = (p[i].m == K_SD);
        if (p[i].wm >= TIMEOUT) begin
          repeat (TIMEOUT) push(s);
          stuck(1'b0);
          return;
        end
        repeat (p[i].wm + 1) push(s);
        if (p[i].m == K_SD) begin
          model_cnt = model_cnt + 1'b1;
          continue;
        end
      end
      s = '0; s.reg_write = 1'b1; s.mem_to_reg = (p[i].m == K_LD);
      push(s);
      model_cnt = model_cnt + 1'b1;
    end
  endtask

  function automatic sig_t observe();
    sig_t o;
    o.imem_req = imem_req; o.ir_write = ir_write; o.pc_write = pc_write;
    o.pc_write_cond = pc_write_cond; o.reg_write = reg_write; o.alu_src_b = alu_src_b;
    o.mem_to_reg = mem_to_reg; o.alu_ctrl = alu_ctrl; o.dmem_req = dmem_req;
    o.dmem_we = dmem_we; o.error = error; o.trap = trap;
    return o;
  endfunction

  // Monitor: every busy cycle must match the next predicted cycle; idle cycles are quiet.
  initial forever begin
    exp_t e;
    sig_t o;
    @(negedge clk);
    if (rst_n) begin
      o = observe();
      checks++;
      if (busy) begin
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_busy cyc=%0d got sig=%h cnt=%0d, none expected", cyc, o, instr_count);
        end else begin
          e = sbq.pop_front();
          if (e.cyc != cyc || o !== e.sig || instr_count !== e.cnt) begin
            errors++;
            $display("FAIL cycle cyc=%0d got sig=%h cnt=%0d, required cyc=%0d sig=%h cnt=%0d",
                     cyc, o, instr_count, e.cyc, e.sig, e.cnt);
          end
        end
      end else if (o !== '0) begin
        errors++;
        $display("FAIL idle_outputs cyc=%0d got sig=%h required 0", cyc, o);
      end
    end
  end

  // Memory responder: waits wf/wm cycles per request; stray readies while req=0.
  bit f_act = 1'b0, m_act = 1'b0;
  int unsigned f_left, m_left;
  instr_t cur;
  initial forever begin
    @(posedge clk); #1;
    if (rst_n) begin
      if (imem_req) begin
        if (!f_act) begin
          f_act = 1'b1;
          if (rq.size() != 0) cur = rq.pop_front();
          else cur = mk(K_ADD, 100000, 0, 1'b1);
          f_left = cur.wf;
        end
        if (f_left == 0) begin
          imem_ready = 1'b1; f_act = 1'b0;
          opcode = cur.op; funct3 = cur.f3; funct7_5 = cur.f75;
          if (cur.last && !(cur.m inside {K_LD, K_SD})) run = 1'b0;
        end else begin
          imem_ready = 1'b0; f_left--;
        end
      end else begin
        imem_ready = 1'($urandom_range(0, 1));
      end
      if (dmem_req) begin
        if (!m_act) begin
          m_act = 1'b1; m_left = cur.wm;
          if (cur.last) run = 1'b0;
        end
        if (m_left == 0) begin
          dmem_ready = 1'b1; m_act = 1'b0;
        end else begin
          dmem_ready = 1'b0; m_left--;
        end
      end else begin
        dmem_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic check_quiet(input string name);
    checks++;
    if (observe() !== '0 || busy !== 1'b0 || instr_count !== '0) begin
      errors++;
      $display("FAIL %s got sig=%h busy=%b cnt=%0d, required all 0", name, observe(), busy, instr_count);
    end
  endtask

  task automatic drain(input int unsigned budget);
    int unsigned n = 0;
    while (sbq.size() != 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d pending, required 0", sbq.size());
      sbq.delete();
    end
  endtask

  // keep > 0 truncates the prediction and resets the DUT right after it.
  task automatic run_phase(input instr_t p[$], input bit end_reset, input int unsigned keep);
    @(posedge clk); #1;
    rq = p;
    mt = cyc + 1;
    model(p);
    if (keep > 0) while (sbq.size() > keep) void'(sbq.pop_back());
    run = 1'b1;
    drain(4000);
    if (end_reset) begin
      rst_n = 1'b0;
      f_act = 1'b0; m_act = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; run = 1'b0;
      #1 check_quiet("async_reset");
      rq.delete();
      model_cnt = '0;
      @(posedge clk); #1 rst_n = 1'b1;
    end else begin
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || instr_count !== model_cnt) begin
        errors++;
        $display("FAIL stop_idle got busy=%b cnt=%0d, required busy=0 cnt=%0d", busy, instr_count, model_cnt);
      end
    end
  endtask

  task automatic random_phase(input int unsigned n);
    instr_t p[$];
    for (int i = 0; i < int'(n); i++) begin
      int unsigned wf, wm;
      mnem_e m;
      wf = ($urandom_range(0, 7) == 0) ? TIMEOUT - 1 : $urandom_range(0, 3);
      wm = ($urandom_range(0, 7) == 0) ? TIMEOUT - 1 : $urandom_range(0, 3);
      m  = mnem_e'($urandom_range(0, TRAP_EN ? 9 : 10));
      p.push_back(mk(m, wf, wm, i == int'(n) - 1));
    end
    run_phase(p, 1'b0, 0);
  endtask

  initial begin
    instr_t p[$];
    @(posedge clk); #1 check_quiet("reset_state");
    rst_n = 1'b1;

    p.delete(); p.push_back(mk(K_ADD, 0, 0, 1'b1));
    run_phase(p, 1'b0, 0);
    p.delete(); p.push_back(mk(K_LD, 0, 3, 1'b1));
    run_phase(p, 1'b0, 0);
    p.delete(); p.push_back(mk(K_BEQ, 0, 0, 1'b0)); p.push_back(mk(K_SUB, 0, 0, 1'b1));
    run_phase(p, 1'b0, 0);
    p.delete(); p.push_back(mk(K_SD, 0, 2, 1'b1));
    run_phase(p, 1'b0, 0);
    p.delete();
    p.push_back(mk(K_OR, TIMEOUT - 1, 0, 1'b0));
    p.push_back(mk(K_LD, 1, TIMEOUT - 1, 1'b0));
    p.push_back(mk(K_SD, 0, TIMEOUT - 1, 1'b0));
    p.push_back(mk(K_ANDI, 0, 0, 1'b1));
    run_phase(p, 1'b0, 0);
    p.delete(); p.push_back(mk(K_ILL, 0, 0, 1'b1));
    run_phase(p, TRAP_EN, 0);

    for (int r = 0; r < 3; r++) random_phase(12);

    p.delete(); p.push_back(mk(K_ADD, 100000, 0, 1'b1));
    run_phase(p, 1'b1, 0);
    p.delete(); p.push_back(mk(K_SD, 0, 100000, 1'b1));
    run_phase(p, 1'b1, 0);
    p.delete(); p.push_back(mk(K_LD, 0, 100000, 1'b1));
    run_phase(p, 1'b1, 6);
    p.delete(); p.push_back(mk(K_ADDI, 0, 0, 1'b1));
    run_phase(p, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no completion, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
